// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - register-file write-port arbiter between the main pipeline and a buffered multi-cycle unit
//
// Ports:
//   clk, rst_n                           clock, synchronous active-low reset
//   PIPE_wr_en/PIPE_rd_sel/PIPE_rd_val   pipeline writeback request (priority, no backpressure except STALL)
//   MCU_req_valid/MCU_rd_sel/MCU_rd_val  multi-cycle unit write request into a 2-entry buffer
//   MCU_req_ready                        buffer has room this cycle
//   WB_wr_en/WB_rd_sel/WB_rd_val/WB_src  registered register-file write (src 0 = pipeline, 1 = MCU)
//   STALL                                registered one-cycle pipeline freeze to drain a starved MCU head
//   PEND_mask                            registers targeted by buffered MCU entries (bit 0 always 0)

module rf_wr_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PIPE_wr_en,
    input  logic [4:0]  PIPE_rd_sel,
    input  logic [31:0] PIPE_rd_val,
    input  logic        MCU_req_valid,
    input  logic [4:0]  MCU_rd_sel,
    input  logic [31:0] MCU_rd_val,
    output logic        MCU_req_ready,
    output logic        WB_wr_en,
    output logic [4:0]  WB_rd_sel,
    output logic [31:0] WB_rd_val,
    output logic        STALL,
    output logic [31:0] PEND_mask,
    output logic        WB_src
);

    // Buffer storage: entry 0 is always the head; a pop shifts entry 1 down.
    logic [1:0]  count;
    logic [4:0]  fifo_sel [2];
    logic [31:0] fifo_val [2];
    logic [3:0]  starve;

    logic        pipe_req;
    logic        fifo_nonempty;
    logic        grant_fifo;
    logic        push;
    logic [1:0]  cnt_after_pop;
    logic [3:0]  starve_next;
    logic        stall_next;

    assign MCU_req_ready = (count != 2'd2);
    assign fifo_nonempty = (count != 2'd0);

    // A pipeline write to r0 is a no-op, and any pipeline write during STALL
    // is re-presented next cycle, so neither competes for the port.
    assign pipe_req   = PIPE_wr_en && (PIPE_rd_sel != 5'd0) && !STALL;
    assign grant_fifo = !pipe_req && fifo_nonempty;

    // r0 requests are handshaken so the MCU can retire them, but never stored.
    assign push          = MCU_req_valid && MCU_req_ready && (MCU_rd_sel != 5'd0);
    assign cnt_after_pop = count - {1'b0, grant_fifo};

    assign starve_next = (!fifo_nonempty || grant_fifo) ? 4'd0 : starve + 4'd1;
    // The stall cycle always grants the head, which clears starve_next, so
    // STALL can never repeat back to back.
    assign stall_next  = (starve_next == 4'(STARVE_MAX));

    // Mask is built from stored entries only: a popped entry drops out once
    // the pop has been registered, and there is no path from PIPE_* inputs.
    always_comb begin
        PEND_mask = 32'd0;
        if (count != 2'd0) begin
            PEND_mask[fifo_sel[0]] = 1'b1;
        end
        if (count == 2'd2) begin
            PEND_mask[fifo_sel[1]] = 1'b1;
        end
        PEND_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= 2'd0;
            fifo_sel[0] <= 5'd0;
            fifo_sel[1] <= 5'd0;
            fifo_val[0] <= 32'd0;
            fifo_val[1] <= 32'd0;
        end else begin
            if (grant_fifo) begin
                fifo_sel[0] <= fifo_sel[1];
                fifo_val[0] <= fifo_val[1];
            end
            // Writing after the shift lets a same-cycle push land behind the
            // surviving entry, preserving order.
            if (push) begin
                if (cnt_after_pop == 2'd0) begin
                    fifo_sel[0] <= MCU_rd_sel;
                    fifo_val[0] <= MCU_rd_val;
                end else begin
                    fifo_sel[1] <= MCU_rd_sel;
                    fifo_val[1] <= MCU_rd_val;
                end
            end
            count <= cnt_after_pop + {1'b0, push};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve    <= 4'd0;
            STALL     <= 1'b0;
            WB_wr_en  <= 1'b0;
            WB_rd_sel <= 5'd0;
            WB_rd_val <= 32'd0;
            WB_src    <= 1'b0;
        end else begin
            starve   <= starve_next;
            STALL    <= stall_next;
            WB_wr_en <= pipe_req || grant_fifo;
            if (pipe_req) begin
                WB_rd_sel <= PIPE_rd_sel;
                WB_rd_val <= PIPE_rd_val;
                WB_src    <= 1'b0;
            end else if (grant_fifo) begin
                WB_rd_sel <= fifo_sel[0];
                WB_rd_val <= fifo_val[0];
                WB_src    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb/tb_rf_wr_arbiter.sv - self-checking bench for rf_wr_arbiter

module tb_rf_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PIPE_wr_en;
    logic [4:0]  PIPE_rd_sel;
    logic [31:0] PIPE_rd_val;
    logic        MCU_req_valid;
    logic [4:0]  MCU_rd_sel;
    logic [31:0] MCU_rd_val;
    logic        MCU_req_ready;
    logic        WB_wr_en;
    logic [4:0]  WB_rd_sel;
    logic [31:0] WB_rd_val;
    logic        STALL;
    logic [31:0] PEND_mask;
    logic        WB_src;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] val;
        logic        src;
    } wr_t;

    wr_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    always #5 clk = ~clk;

    rf_wr_arbiter #(.STARVE_MAX(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PIPE_wr_en    (PIPE_wr_en),
        .PIPE_rd_sel   (PIPE_rd_sel),
        .PIPE_rd_val   (PIPE_rd_val),
        .MCU_req_valid (MCU_req_valid),
        .MCU_rd_sel    (MCU_rd_sel),
        .MCU_rd_val    (MCU_rd_val),
        .MCU_req_ready (MCU_req_ready),
        .WB_wr_en      (WB_wr_en),
        .WB_rd_sel     (WB_rd_sel),
        .WB_rd_val     (WB_rd_val),
        .STALL         (STALL),
        .PEND_mask     (PEND_mask),
        .WB_src        (WB_src)
    );

    // Scoreboard: every register-file write must match the next expected one.
    always @(negedge clk) begin
        wr_t e;
        if (WB_wr_en === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL wb_unexpected: got rd=%0d val=%h src=%b, required no write",
                         WB_rd_sel, WB_rd_val, WB_src);
            end else begin
                e = exp_q.pop_front();
                if ({WB_rd_sel, WB_rd_val, WB_src} !== e) begin
                    miscompares++;
                    $display("FAIL wb_data: got rd=%0d val=%h src=%b, required rd=%0d val=%h src=%b",
                             WB_rd_sel, WB_rd_val, WB_src, e.sel, e.val, e.src);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        PIPE_wr_en    = 1'b0;
        PIPE_rd_sel   = 5'd0;
        PIPE_rd_val   = 32'd0;
        MCU_req_valid = 1'b0;
        MCU_rd_sel    = 5'd0;
        MCU_rd_val    = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        vectors++;
        if ({WB_wr_en, STALL, WB_src} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got wr_en/stall/src=%b, required 000", {WB_wr_en, STALL, WB_src});
        end
        vectors++;
        if ({WB_rd_sel, WB_rd_val} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_wb: got rd=%0d val=%h, required 0", WB_rd_sel, WB_rd_val);
        end
        vectors++;
        if (MCU_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b, required 1", MCU_req_ready);
        end
        vectors++;
        if (PEND_mask !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mask: got %h, required 0", PEND_mask);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pipe_write();
        PIPE_wr_en  = 1'b1;
        PIPE_rd_sel = 5'd5;
        PIPE_rd_val = 32'hDEADBEEF;
        exp_q.push_back('{sel: 5'd5, val: 32'hDEADBEEF, src: 1'b0});
        @(negedge clk);
        idle_inputs();
        vectors++;
        if (WB_wr_en !== 1'b1) begin
            miscompares++;
            $display("FAIL pipe_latency: got wr_en=%b, required 1", WB_wr_en);
        end
        @(negedge clk);
        vectors++;
        if ({WB_wr_en, WB_rd_sel, WB_src} !== {1'b0, 5'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL pipe_hold: got wr_en=%b rd=%0d src=%b, required 0/5/0", WB_wr_en, WB_rd_sel, WB_src);
        end
    endtask

    task automatic test_mcu_write();
        vectors++;
        if (MCU_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mcu_ready: got %b, required 1", MCU_req_ready);
        end
        MCU_req_valid = 1'b1;
        MCU_rd_sel    = 5'd7;
        MCU_rd_val    = 32'h12;
        exp_q.push_back('{sel: 5'd7, val: 32'h12, src: 1'b1});
        @(negedge clk);
        idle_inputs();
        vectors++;
        if (PEND_mask !== 32'h0000_0080) begin
            miscompares++;
            $display("FAIL mcu_pend: got %h, required 00000080", PEND_mask);
        end
        vectors++;
        if (WB_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL mcu_no_bypass: got wr_en=%b, required 0", WB_wr_en);
        end
        @(negedge clk);
        vectors++;
        if ({WB_wr_en, WB_src, PEND_mask} !== {2'b11, 32'd0}) begin
            miscompares++;
            $display("FAIL mcu_wb: got wr_en=%b src=%b mask=%h, required 1/1/0", WB_wr_en, WB_src, PEND_mask);
        end
        @(negedge clk);
    endtask

    task automatic test_starve();
        int idx = 0;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (STALL !== (c == 5)) begin
                miscompares++;
                $display("FAIL starve_stall c=%0d: got %b, required %b", c, STALL, (c == 5));
            end
            PIPE_wr_en    = 1'b1;
            PIPE_rd_sel   = 5'(idx + 1);
            PIPE_rd_val   = 32'hA000_0000 + 32'(idx);
            MCU_req_valid = (c == 0);
            MCU_rd_sel    = 5'd9;
            MCU_rd_val    = 32'h99;
            if (c == 5) begin
                exp_q.push_back('{sel: 5'd9, val: 32'h99, src: 1'b1});
            end else begin
                exp_q.push_back('{sel: 5'(idx + 1), val: 32'hA000_0000 + 32'(idx), src: 1'b0});
                idx++;
            end
            @(negedge clk);
        end
        idle_inputs();
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL starve_drain: got %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] rdy = 7'b1000011;
        int idx = 0;
        int j   = 0;
        int k   = 0;
        for (int c = 0; c < 18; c++) begin
            logic stall_exp;
            stall_exp = (c == 5) || (c == 10) || (c == 15);
            vectors++;
            if (STALL !== stall_exp) begin
                miscompares++;
                $display("FAIL b2b_stall c=%0d: got %b, required %b", c, STALL, stall_exp);
            end
            if (c <= 6) begin
                vectors++;
                if (MCU_req_ready !== rdy[c]) begin
                    miscompares++;
                    $display("FAIL b2b_ready c=%0d: got %b, required %b", c, MCU_req_ready, rdy[c]);
                end
            end
            MCU_req_valid = (j < 3);
            MCU_rd_sel    = 5'(11 + j);
            MCU_rd_val    = 32'hB0 + 32'(j);
            if (j < 3 && c <= 6 && rdy[c]) j++;
            PIPE_wr_en  = 1'b1;
            PIPE_rd_sel = 5'((idx % 30) + 1);
            PIPE_rd_val = 32'hC000_0000 + 32'(idx);
            if (stall_exp) begin
                exp_q.push_back('{sel: 5'(11 + k), val: 32'hB0 + 32'(k), src: 1'b1});
                k++;
            end else begin
                exp_q.push_back('{sel: 5'((idx % 30) + 1), val: 32'hC000_0000 + 32'(idx), src: 1'b0});
                idx++;
            end
            @(negedge clk);
        end
        idle_inputs();
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() !== 0 || PEND_mask !== 32'd0) begin
            miscompares++;
            $display("FAIL b2b_drain: got %0d outstanding mask=%h, required 0/0", exp_q.size(), PEND_mask);
        end
    endtask

    task automatic test_zero_sel();
        vectors++;
        if (MCU_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_ready: got %b, required 1", MCU_req_ready);
        end
        MCU_req_valid = 1'b1;
        MCU_rd_sel    = 5'd0;
        MCU_rd_val    = 32'h55;
        PIPE_wr_en    = 1'b1;
        PIPE_rd_sel   = 5'd0;
        PIPE_rd_val   = 32'h66;
        @(negedge clk);
        idle_inputs();
        vectors++;
        if ({WB_wr_en, PEND_mask, MCU_req_ready} !== {1'b0, 32'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL zero_first: got wr_en=%b mask=%h ready=%b, required 0/0/1", WB_wr_en, PEND_mask, MCU_req_ready);
        end
        @(negedge clk);
        vectors++;
        if ({WB_wr_en, PEND_mask} !== 33'd0) begin
            miscompares++;
            $display("FAIL zero_second: got wr_en=%b mask=%h, required 0/0", WB_wr_en, PEND_mask);
        end
    endtask

    task automatic test_reset_full();
        MCU_req_valid = 1'b1;
        MCU_rd_sel    = 5'd3;
        MCU_rd_val    = 32'h33;
        PIPE_wr_en    = 1'b1;
        PIPE_rd_sel   = 5'd20;
        PIPE_rd_val   = 32'h2020;
        exp_q.push_back('{sel: 5'd20, val: 32'h2020, src: 1'b0});
        @(negedge clk);
        MCU_rd_sel    = 5'd4;
        MCU_rd_val    = 32'h44;
        PIPE_rd_sel   = 5'd21;
        PIPE_rd_val   = 32'h2121;
        exp_q.push_back('{sel: 5'd21, val: 32'h2121, src: 1'b0});
        @(negedge clk);
        vectors++;
        if ({PEND_mask, MCU_req_ready} !== {32'h0000_0018, 1'b0}) begin
            miscompares++;
            $display("FAIL rstfull_full: got mask=%h ready=%b, required 00000018/0", PEND_mask, MCU_req_ready);
        end
        rst_n       = 1'b0;
        MCU_rd_sel  = 5'd6;
        PIPE_rd_sel = 5'd22;
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        vectors++;
        if ({MCU_req_ready, PEND_mask} !== {1'b1, 32'd0}) begin
            miscompares++;
            $display("FAIL rstfull_fifo: got ready=%b mask=%h, required 1/0", MCU_req_ready, PEND_mask);
        end
        vectors++;
        if ({WB_wr_en, WB_rd_sel, WB_rd_val, WB_src, STALL} !== 40'd0) begin
            miscompares++;
            $display("FAIL rstfull_out: got wr_en=%b rd=%0d val=%h src=%b stall=%b, required all 0",
                     WB_wr_en, WB_rd_sel, WB_rd_val, WB_src, STALL);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (exp_q.size() !== 0 || PEND_mask !== 32'd0) begin
            miscompares++;
            $display("FAIL rstfull_drain: got %0d outstanding mask=%h, required 0/0", exp_q.size(), PEND_mask);
        end
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_mcu_write();
        test_starve();
        test_back_to_back();
        test_zero_sel();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
